// File: rtl/step_down_counter_pkg.sv
// Shared constants for the step-down counter: debounce lengths for the board and
// for simulation, plus the width of the debounce stability counter.
package step_down_counter_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;  // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/step_down_counter_button_conditioner.sv
// Button conditioner: 2-FF synchroniser, stability-count debouncer and a
// registered one-cycle rising-edge pulse of the debounced level.
module button_conditioner
    import step_down_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic btnU,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_pulse;

    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Any disagreement that does not last DEBOUNCE_CYCLES cycles restarts the count.
    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule

// File: rtl/step_down_counter.sv
// Down counter driven by debounced step (btnC) and load (btnL) buttons, with a
// one-cycle borrow pulse on the 0 -> max wrap and a zero flag.
module step_down_counter
    import step_down_counter_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             btnU,
    input  logic             btnC,
    input  logic             btnL,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             borrow
);

    logic [1:0]       w_btn_raw;
    logic [1:0]       w_pulse;
    logic             w_step;
    logic             w_load;
    logic [WIDTH-1:0] r_q;
    logic             r_borrow;

    // Index 0 is the step button, index 1 the load button.
    assign w_btn_raw = {btnL, btnC};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cond (
                .clk    (clk),
                .btnU   (btnU),
                .btn_raw(w_btn_raw[gi]),
                .level  (),
                .pulse  (w_pulse[gi])
            );
        end
    endgenerate

    assign w_step = w_pulse[0];
    assign w_load = w_pulse[1];

    // Load has priority; a step arriving in the same cycle is dropped.
    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            r_q      <= '0;
            r_borrow <= 1'b0;
        end else if (w_load) begin
            r_q      <= sw;
            r_borrow <= 1'b0;
        end else if (w_step) begin
            r_q      <= r_q - WIDTH'(1);
            r_borrow <= (r_q == '0);
        end else begin
            r_borrow <= 1'b0;
        end
    end

    assign Q      = r_q;
    assign zero   = (r_q == '0);
    assign borrow = r_borrow;

endmodule

// File: tb/tb_step_down_counter.sv
// Self-checking bench for step_down_counter (WIDTH=3, DEBOUNCE_CYCLES=4): vector
// table of button operations feeding a scoreboard checked by a cycle monitor.
module tb_step_down_counter;
    import step_down_counter_pkg::*;

    localparam int W = 3;

    typedef enum {OP_LOAD, OP_STEP, OP_BOTH, OP_BOUNCE} op_e;

    typedef struct {
        op_e          op;
        logic [W-1:0] sw;
        logic [W-1:0] exp_q;
        logic         exp_borrow;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic         borrow;
        int           lat;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         btnU = 1'b0;
    logic         btnC = 1'b0;
    logic         btnL = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] Q;
    logic         zero;
    logic         borrow;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    bit   mon_en = 1'b0;
    logic [W-1:0] prev_q = '0;
    logic         prev_b = 1'b0;
    exp_t sb_q[$];
    exp_t e;
    vec_t vecs[12];

    step_down_counter #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
    ) dut (
        .clk   (clk),
        .btnU  (btnU),
        .btnC  (btnC),
        .btnL  (btnL),
        .sw    (sw),
        .Q     (Q),
        .zero  (zero),
        .borrow(borrow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: every Q change or borrow pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_b) begin
                checks++;
                if (borrow !== 1'b0) begin
                    errors++;
                    $display("FAIL borrow_one_cycle: borrow=%b required 0", borrow);
                end
            end
            if (Q !== prev_q || borrow !== 1'b0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: Q=%0d borrow=%b required Q=%0d borrow=0", Q, borrow, prev_q);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn %s: Q=%0d zero=%b borrow=%b latency=%0d", e.name, Q, zero, borrow, cyc - rise_cyc);
                    checks += 3;
                    if (Q !== e.q) begin
                        errors++;
                        $display("FAIL %s_q: Q=%0d required %0d", e.name, Q, e.q);
                    end
                    if (borrow !== e.borrow) begin
                        errors++;
                        $display("FAIL %s_borrow: borrow=%b required %b", e.name, borrow, e.borrow);
                    end
                    if (zero !== (e.q == '0)) begin
                        errors++;
                        $display("FAIL %s_zero: zero=%b required %b", e.name, zero, (e.q == '0));
                    end
                    if (e.lat >= 0) begin
                        checks++;
                        if (cyc - rise_cyc != e.lat) begin
                            errors++;
                            $display("FAIL %s_latency: %0d cycles required %0d", e.name, cyc - rise_cyc, e.lat);
                        end
                    end
                end
            end
            prev_q = Q;
            prev_b = borrow;
        end
    end

    function automatic vec_t mk(op_e op, logic [W-1:0] s, logic [W-1:0] q, logic b, string n);
        vec_t v;
        v.op = op; v.sw = s; v.exp_q = q; v.exp_borrow = b; v.name = n;
        return v;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit c, input bit l);
        wait_cycles(1);
        btnC = c;
        btnL = l;
        rise_cyc = cyc;
        wait_cycles(10);
        btnC = 1'b0;
        btnL = 1'b0;
        wait_cycles(16);
    endtask

    task automatic bounce_press();
        wait_cycles(1);
        for (int k = 0; k < 20; k++) begin
            btnC = ((k / 2) % 2 == 0);
            wait_cycles(1);
        end
        btnC = 1'b1;
        rise_cyc = cyc;
        wait_cycles(12);
        for (int k = 0; k < 10; k++) begin
            btnC = ((k / 2) % 2 == 1);
            wait_cycles(1);
        end
        btnC = 1'b0;
        wait_cycles(16);
    endtask

    task automatic check_val(input string name, input logic [W-1:0] act_q, input logic [W-1:0] req_q,
                             input logic act_z, input logic act_b);
        checks++;
        if (act_q !== req_q || act_z !== (req_q == '0) || act_b !== 1'b0) begin
            errors++;
            $display("FAIL %s: Q=%0d zero=%b borrow=%b required Q=%0d zero=%b borrow=0",
                     name, act_q, act_z, act_b, req_q, (req_q == '0));
        end else begin
            $display("txn %s: Q=%0d zero=%b borrow=%b", name, act_q, act_z, act_b);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected updates not seen, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic push_exp(input logic [W-1:0] q, input logic b, input int lat, input string n);
        exp_t x;
        x.q = q; x.borrow = b; x.lat = lat; x.name = n;
        sb_q.push_back(x);
    endtask

    initial begin
        vecs[0]  = mk(OP_LOAD,   3'd5, 3'd5, 1'b0, "load5");
        vecs[1]  = mk(OP_STEP,   3'd5, 3'd4, 1'b0, "step4");
        vecs[2]  = mk(OP_STEP,   3'd5, 3'd3, 1'b0, "step3");
        vecs[3]  = mk(OP_STEP,   3'd5, 3'd2, 1'b0, "step2");
        vecs[4]  = mk(OP_STEP,   3'd5, 3'd1, 1'b0, "step1");
        vecs[5]  = mk(OP_STEP,   3'd5, 3'd0, 1'b0, "step0");
        vecs[6]  = mk(OP_STEP,   3'd5, 3'd7, 1'b1, "wrap");
        vecs[7]  = mk(OP_BOUNCE, 3'd5, 3'd6, 1'b0, "bounce");
        vecs[8]  = mk(OP_STEP,   3'd5, 3'd5, 1'b0, "step5");
        vecs[9]  = mk(OP_BOTH,   3'd6, 3'd6, 1'b0, "priority");
        vecs[10] = mk(OP_LOAD,   3'd0, 3'd0, 1'b0, "load0");
        vecs[11] = mk(OP_STEP,   3'd0, 3'd7, 1'b1, "wrap2");

        // Asynchronous reset before the first clock edge.
        #3 btnU = 1'b1;
        #1 check_val("reset_async", Q, 3'd0, zero, borrow);
        wait_cycles(3);
        btnU = 1'b0;
        prev_q = Q;
        prev_b = borrow;
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            sw = vecs[i].sw;
            push_exp(vecs[i].exp_q, vecs[i].exp_borrow, 8, vecs[i].name);
            case (vecs[i].op)
                OP_LOAD:   press(1'b0, 1'b1);
                OP_STEP:   press(1'b1, 1'b0);
                OP_BOTH:   press(1'b1, 1'b1);
                default:   bounce_press();
            endcase
            check_drained(vecs[i].name);
        end

        // Reset two cycles into a step debounce: the pending step must vanish.
        wait_cycles(1);
        btnC = 1'b1;
        wait_cycles(4);
        mon_en = 1'b0;
        btnU = 1'b1;
        #1 check_val("reset_mid", Q, 3'd0, zero, borrow);
        btnC = 1'b0;
        wait_cycles(3);
        btnU = 1'b0;
        prev_q = 3'd0;
        prev_b = 1'b0;
        mon_en = 1'b1;
        wait_cycles(20);
        check_val("reset_no_step", Q, 3'd0, zero, borrow);
        check_drained("reset_no_step");

        // Step button held through reset release: exactly one step to 7 with borrow.
        btnC = 1'b1;
        mon_en = 1'b0;
        btnU = 1'b1;
        wait_cycles(3);
        push_exp(3'd7, 1'b1, 8, "held_reset");
        btnU = 1'b0;
        rise_cyc = cyc;
        prev_q = 3'd0;
        prev_b = 1'b0;
        mon_en = 1'b1;
        wait_cycles(12);
        btnC = 1'b0;
        wait_cycles(16);
        check_drained("held_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
